// File: rtl/uart_tx_if.sv
// Write-side handshake and serial line of the UART transmitter.
// The master drives the byte strobe and the slave reports FIFO status plus txd.
interface uart_tx_if;
    logic [7:0] uart_tx_data;
    logic       uart_tx_req;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_overflow;
    logic       txd;

    modport master (
        output uart_tx_data, uart_tx_req,
        input  tx_ready, tx_busy, tx_overflow, txd
    );

    modport slave (
        input  uart_tx_data, uart_tx_req,
        output tx_ready, tx_busy, tx_overflow, txd
    );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed by a write FIFO.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 496,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input logic  clk,
    input logic  reset,
    uart_tx_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    localparam logic [15:0] BitLast = 16'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks
        $error("uart_tx: CLKS_PER_BIT out of range");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
    begin : g_bad_depth
        $error("uart_tx: FIFO_DEPTH must be a power of two in 2..256");
    end

    state_e      state_q, state_d;
    logic [15:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        overflow_q;
    logic        txd;
    logic        bit_done;
    logic        fifo_empty, fifo_full;
    logic        push, pop;
    logic [7:0]  fifo_head;

    assign bit_done = (bit_cnt_q == '0);
    // Full is judged before the edge, so a same-cycle pop never rescues a write.
    assign push     = bus.uart_tx_req && !fifo_full;

`ifdef UART_TX_FIFO_EN
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (!push && pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.uart_tx_data;
    end

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FullCnt);
    assign fifo_head  = mem_q[rd_ptr_q];
`else
    logic [7:0] hold_q;
    logic       hold_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
        end else if (push) begin
            hold_valid_q <= 1'b1;
            hold_q       <= bus.uart_tx_data;
        end else if (pop) begin
            hold_valid_q <= 1'b0;
        end
    end

    assign fifo_empty = !hold_valid_q;
    assign fifo_full  = hold_valid_q;
    assign fifo_head  = hold_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            bit_cnt_q  <= BitLast;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            if (bus.uart_tx_req && fifo_full) overflow_q <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        if (state_q != StIdle) begin
            bit_cnt_d = bit_done ? BitLast : bit_cnt_q - 16'd1;
        end
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_d   = StStart;
                    bit_cnt_d = BitLast;
                    shift_d   = fifo_head;
                end
            end
            StStart: begin
                if (bit_done) begin
                    state_d   = StData;
                    bit_idx_d = '0;
                end
            end
            StData: begin
                if (bit_done) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            StStop: begin
                if (bit_done) begin
                    // Chain straight into the next start bit so frames have no idle gap.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = StStart;
                        shift_d = fifo_head;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        txd = 1'b1;
        case (state_q)
            StStart: txd = 1'b0;
            StData:  txd = shift_q[bit_idx_q];
            default: txd = 1'b1;
        endcase
    end

    assign bus.txd         = txd;
    assign bus.tx_ready    = !fifo_full;
    assign bus.tx_busy     = !fifo_empty || (state_q != StIdle);
    assign bus.tx_overflow = overflow_q;
endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Adapts to UART_TX_FIFO_EN: effective depth 4 with the macro, 1 without.
module tb_uart_tx;
    localparam int unsigned Clks = 4;
`ifdef UART_TX_FIFO_EN
    localparam int unsigned D = 4;
`else
    localparam int unsigned D = 1;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    uart_tx_if bus ();

    uart_tx #(
        .CLKS_PER_BIT(Clks),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe one byte for a single cycle; returns one cycle after the sampling edge.
    task automatic write(input logic [7:0] b);
        bus.uart_tx_data = b;
        bus.uart_tx_req  = 1'b1;
        tick();
        bus.uart_tx_req  = 1'b0;
    endtask

    // Called on the first start-bit cycle; returns on the cycle after the stop bit.
    task automatic check_frame(input logic [7:0] b, input string tag);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < Clks; j++) begin
                check($sformatf("%s bit%0d cyc%0d", tag, i, j), 8'(bus.txd), 8'(bits[i]));
                tick();
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.uart_tx_data = '0;
        bus.uart_tx_req  = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        check("rst txd", 8'(bus.txd), 8'd1);
        check("rst ready", 8'(bus.tx_ready), 8'd1);
        check("rst busy", 8'(bus.tx_busy), 8'd0);
        check("rst ovf", 8'(bus.tx_overflow), 8'd0);
        reset = 1'b0;
        tick();

        // Single byte from idle: start bit two cycles after the strobe.
        write(8'h55);
        check("55 busy", 8'(bus.tx_busy), 8'd1);
        check("55 txd early", 8'(bus.txd), 8'd1);
        check("55 ready", 8'(bus.tx_ready), 8'(D > 1));
        tick();
        check_frame(8'h55, "f55");
        check("55 busy end", 8'(bus.tx_busy), 8'd0);
        check("55 ready end", 8'(bus.tx_ready), 8'd1);

`ifdef UART_TX_FIFO_EN
        write(8'h41);
        write(8'h42);
        check_frame(8'h41, "f41");
        check_frame(8'h42, "f42");
        check("4142 busy", 8'(bus.tx_busy), 8'd0);
        check("4142 ovf", 8'(bus.tx_overflow), 8'd0);
`else
        write(8'h01);
        write(8'h02);
        check("0102 ovf", 8'(bus.tx_overflow), 8'd1);
        check_frame(8'h01, "f01");
        check("0102 busy", 8'(bus.tx_busy), 8'd0);
        for (int k = 0; k < 8; k++) begin
            check("0102 no 2nd", 8'(bus.txd), 8'd1);
            tick();
        end
`endif
        do_reset();
        tick();

        // Fill while a frame is in flight; one extra write is dropped.
        write(8'h10);
        tick();
        for (int k = 0; k <= int'(D); k++) begin
            write(8'hA1 + 8'(k));
            check($sformatf("fill ovf %0d", k), 8'(bus.tx_overflow), 8'(k == int'(D)));
            check($sformatf("fill ready %0d", k), 8'(bus.tx_ready), 8'(k + 1 < int'(D)));
        end
        repeat (39 - D) tick();
        for (int k = 0; k < int'(D); k++) begin
            check_frame(8'hA1 + 8'(k), $sformatf("fA%0d", k + 1));
        end
        check("fill busy end", 8'(bus.tx_busy), 8'd0);
        check("fill ovf sticky", 8'(bus.tx_overflow), 8'd1);

        // Reset in the middle of a frame, with a write strobed during reset.
        write(8'hC3);
        tick();
        repeat (15) tick();
        check("C3 mid txd", 8'(bus.txd), 8'd0);
        reset = 1'b1;
        bus.uart_tx_data = 8'hFF;
        bus.uart_tx_req  = 1'b1;
        tick();
        check("midrst txd", 8'(bus.txd), 8'd1);
        check("midrst busy", 8'(bus.tx_busy), 8'd0);
        check("midrst ovf", 8'(bus.tx_overflow), 8'd0);
        check("midrst ready", 8'(bus.tx_ready), 8'd1);
        tick();
        reset = 1'b0;
        bus.uart_tx_req = 1'b0;
        tick();
        check("postrst busy", 8'(bus.tx_busy), 8'd0);
        check("postrst txd", 8'(bus.txd), 8'd1);
        write(8'hA5);
        check("A5 txd early", 8'(bus.txd), 8'd1);
        tick();
        check_frame(8'hA5, "fA5");
        check("A5 busy end", 8'(bus.tx_busy), 8'd0);

        // Full FIFO with a write landing on the stop-to-start pop edge.
        write(8'hB0);
        tick();
        for (int k = 0; k < int'(D); k++) write(8'hB1 + 8'(k));
        repeat (39 - D) tick();
        check("pre-pop ovf", 8'(bus.tx_overflow), 8'd0);
        check("pre-pop ready", 8'(bus.tx_ready), 8'd0);
        write(8'hEE);
        check("pop-edge ovf", 8'(bus.tx_overflow), 8'd1);
        check("pop-edge ready", 8'(bus.tx_ready), 8'd1);
        for (int k = 0; k < int'(D); k++) begin
            check_frame(8'hB1 + 8'(k), $sformatf("fB%0d", k + 1));
        end
        check("B busy end", 8'(bus.tx_busy), 8'd0);

        // More single writes to walk the pointers around again.
        for (int k = 0; k < 7; k++) begin
            write(8'h3C ^ 8'(k * 37));
            tick();
            check_frame(8'h3C ^ 8'(k * 37), $sformatf("fW%0d", k));
        end
        check("wrap busy end", 8'(bus.tx_busy), 8'd0);
        check("wrap ovf sticky", 8'(bus.tx_overflow), 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
